alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core.sv | 126 ++++++++++++
 tb/tb_alu_core.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: single-cycle registered ALU with carry/sign/overflow/zero flags.
// HLT freezes all outputs until a synchronous reset clears the halt.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] operando_a,
    input  logic [WIDTH-1:0] operando_b,
    input  logic [4:0]       opcode,
    output logic [WIDTH-1:0] resultado,
    output logic             C,
    output logic             S,
    output logic             O,
    output logic             Z,
    output logic             halted
);

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_AND = 5'b00011;
    localparam logic [4:0] OP_OR  = 5'b00100;
    localparam logic [4:0] OP_NOT = 5'b00101;
    localparam logic [4:0] OP_NEG = 5'b00110;
    localparam logic [4:0] OP_HLT = 5'b11111;

    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic             s_q, s_d;
    logic             o_q, o_d;
    logic             z_q, z_d;
    logic             halt_q, halt_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [WIDTH:0]   neg_w;
    logic             sa, sb;
    logic             exec;

    assign sa    = operando_a[WIDTH-1];
    assign sb    = operando_b[WIDTH-1];
    // Extra MSB carries the carry-out / borrow of each arithmetic op.
    assign sum_w = {1'b0, operando_a} + {1'b0, operando_b};
    assign dif_w = {1'b0, operando_a} - {1'b0, operando_b};
    assign neg_w = {(WIDTH+1){1'b0}} - {1'b0, operando_a};

    always_comb begin
        res_d  = res_q;
        c_d    = c_q;
        o_d    = o_q;
        halt_d = halt_q;
        exec   = 1'b0;
        if (!halt_q) begin
            case (opcode)
                OP_ADD: begin
                    exec  = 1'b1;
                    res_d = sum_w[WIDTH-1:0];
                    c_d   = sum_w[WIDTH];
                    o_d   = (sa == sb) && (sum_w[WIDTH-1] != sa);
                end
                OP_SUB: begin
                    exec  = 1'b1;
                    res_d = dif_w[WIDTH-1:0];
                    c_d   = dif_w[WIDTH];
                    o_d   = (sa != sb) && (dif_w[WIDTH-1] != sa);
                end
                OP_AND: begin
                    exec  = 1'b1;
                    res_d = operando_a & operando_b;
                    c_d   = 1'b0;
                    o_d   = 1'b0;
                end
                OP_OR: begin
                    exec  = 1'b1;
                    res_d = operando_a | operando_b;
                    c_d   = 1'b0;
                    o_d   = 1'b0;
                end
                OP_NOT: begin
                    exec  = 1'b1;
                    res_d = ~operando_a;
                    c_d   = 1'b0;
                    o_d   = 1'b0;
                end
                OP_NEG: begin
                    exec  = 1'b1;
                    res_d = neg_w[WIDTH-1:0];
                    c_d   = neg_w[WIDTH];
                    o_d   = sa && (neg_w[WIDTH-1] == 1'b1);
                end
                OP_HLT:  halt_d = 1'b1;
                OP_NOP:  exec = 1'b0;
                default: exec = 1'b0;
            endcase
        end
        s_d = exec ? res_d[WIDTH-1] : s_q;
        z_d = exec ? (res_d == '0) : z_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            c_q    <= 1'b0;
            s_q    <= 1'b0;
            o_q    <= 1'b0;
            z_q    <= 1'b1;
            halt_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            c_q    <= c_d;
            s_q    <= s_d;
            o_q    <= o_d;
            z_q    <= z_d;
            halt_q <= halt_d;
        end
    end

    assign resultado = res_q;
    assign C         = c_q;
    assign S         = s_q;
    assign O         = o_q;
    assign Z         = z_q;
    assign halted    = halt_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors plus random ops against an integer-arithmetic
// reference model of the ALU.
module tb_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] operando_a, operando_b;
    logic [4:0]  opcode;
    logic [31:0] resultado;
    logic        C, S, O, Z, halted;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_res;
    logic        m_c, m_s, m_o, m_z, m_halt;

    alu_core #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .operando_a(operando_a), .operando_b(operando_b),
        .opcode(opcode), .resultado(resultado),
        .C(C), .S(S), .O(O), .Z(Z), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ovf(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    task automatic model(input logic r, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        longint full;
        longint sv;
        bit     ex;
        ex = 1'b0;
        if (r) begin
            m_res = 0; m_c = 0; m_s = 0; m_o = 0; m_z = 1; m_halt = 0;
        end else if (!m_halt) begin
            case (op)
                5'd1: begin
                    full  = longint'(a) + longint'(b);
                    sv    = longint'($signed(a)) + longint'($signed(b));
                    m_res = full[31:0];
                    m_c   = full >= 64'sd4294967296;
                    m_o   = ovf(sv);
                    ex    = 1;
                end
                5'd2: begin
                    sv    = longint'($signed(a)) - longint'($signed(b));
                    m_res = a - b;
                    m_c   = a < b;
                    m_o   = ovf(sv);
                    ex    = 1;
                end
                5'd3: begin m_res = a & b; m_c = 0; m_o = 0; ex = 1; end
                5'd4: begin m_res = a | b; m_c = 0; m_o = 0; ex = 1; end
                5'd5: begin m_res = ~a;    m_c = 0; m_o = 0; ex = 1; end
                5'd6: begin
                    sv    = -longint'($signed(a));
                    m_res = 32'd0 - a;
                    m_c   = a != 0;
                    m_o   = ovf(sv);
                    ex    = 1;
                end
                5'd31: m_halt = 1;
                default: ;
            endcase
            if (ex) begin
                m_s = m_res[31];
                m_z = m_res == 0;
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        rst = r; opcode = op; operando_a = a; operando_b = b;
        @(posedge clk);
        model(r, op, a, b);
        #1;
        chk({tag, ".res"}, resultado, m_res);
        chk({tag, ".C"}, 32'(C), 32'(m_c));
        chk({tag, ".S"}, 32'(S), 32'(m_s));
        chk({tag, ".O"}, 32'(O), 32'(m_o));
        chk({tag, ".Z"}, 32'(Z), 32'(m_z));
        chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    endtask

    logic [4:0] ops [10];

    initial begin
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd17, 5'd30};
        m_res = 0; m_c = 0; m_s = 0; m_o = 0; m_z = 1; m_halt = 0;

        step("rst", 1, 5'd1, 32'h1234, 32'h1);
        chk("rst_res_const", resultado, 32'h0);
        chk("rst_z_const", 32'(Z), 32'h1);

        step("add_min", 0, 5'd1, 32'h80000000, 32'h80000000);
        step("add_ovf", 0, 5'd1, 32'h7FFF0000, 32'h7FFF1111);
        chk("add_ovf_const", resultado, 32'hFFFE1111);
        step("add_cy", 0, 5'd1, 32'hFFFF0000, 32'hFFFFFFFF);
        step("sub_brw", 0, 5'd2, 32'h0, 32'h1);
        step("sub_eq", 0, 5'd2, 32'h05050505, 32'h05050505);
        step("nop", 0, 5'd0, 32'hDEAD, 32'hBEEF);
        step("neg", 0, 5'd6, 32'hF0F0F0F0, 32'h0);
        chk("neg_const", resultado, 32'h0F0F0F10);
        step("neg0", 0, 5'd6, 32'h0, 32'h5);
        step("neg_min", 0, 5'd6, 32'h80000000, 32'h0);
        step("not", 0, 5'd5, 32'h0000FFFF, 32'h0);
        step("and", 0, 5'd3, 32'h00001111, 32'h10100011);
        chk("and_const", resultado, 32'h00000011);
        step("or", 0, 5'd4, 32'hFFFF0000, 32'h0000FFFF);
        step("unl", 0, 5'd9, 32'h1, 32'h1);

        step("add5", 0, 5'd1, 32'd2, 32'd3);
        step("hlt", 0, 5'd31, 32'd7, 32'd7);
        step("halted_add", 0, 5'd1, 32'd1, 32'd1);
        chk("halt_hold_const", resultado, 32'd5);
        step("rst_hlt", 1, 5'd31, 32'd1, 32'd1);
        step("resume", 0, 5'd1, 32'd1, 32'd1);

        for (int i = 0; i < 2000; i++) begin
            logic       r;
            logic [4:0] op;
            r = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) op = 5'd31;
            else op = ops[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
                0: step("rnd", r, op, 32'h80000000, $urandom);
                1: step("rnd", r, op, $urandom, $urandom & 32'hF);
                default: step("rnd", r, op, $urandom, $urandom);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
